// File: rtl/acia_rx_fifo.sv
// Receive FIFO between the ACIA receiver strobe and the CPU data register.
// First-word-fall-through: the head byte and its error bit are visible without a pop.
module acia_rx_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int THRESH = 8,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [7:0]    wr_dat,
  input  logic          wr_err,
  input  logic          wr_stb,
  input  logic          rd_stb,
  output logic [7:0]    rd_dat,
  output logic          rd_err,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          above_thresh,
  output logic          overrun
);

  localparam int AW     = $clog2(DEPTH);
  localparam int DATA_W = 8;

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            overrun_q;
  logic            pop_ok;
  logic            push_ok;
  logic [DATA_W:0] head;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign above_thresh = (count_q >= CW'(THRESH));
  assign count        = count_q;
  assign overrun      = overrun_q;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign pop_ok  = rd_stb & ~empty;
  assign push_ok = wr_stb & (~full | pop_ok);

  assign head   = mem[rd_ptr];
  assign rd_dat = empty ? '0 : head[DATA_W-1:0];
  assign rd_err = empty ? 1'b0 : head[DATA_W];

  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem[wr_ptr] <= {wr_err, wr_dat};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr_stb && !push_ok) begin
        overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Bench for acia_rx_fifo: directed and random steps checked against a queue model.
module tb_acia_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [7:0]    wr_dat = 8'h00;
  logic          wr_err = 1'b0;
  logic          wr_stb = 1'b0;
  logic          rd_stb = 1'b0;
  logic [7:0]    rd_dat;
  logic          rd_err;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          above_thresh;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  logic [8:0] q[$];
  logic       m_ovr = 1'b0;

  acia_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_dat(wr_dat), .wr_err(wr_err), .wr_stb(wr_stb), .rd_stb(rd_stb),
    .rd_dat(rd_dat), .rd_err(rd_err), .empty(empty), .full(full),
    .count(count), .above_thresh(above_thresh), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("above_thresh", 32'(above_thresh), 32'(n >= THRESH));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("rd_dat", 32'(rd_dat), (n > 0) ? 32'(q[0][7:0]) : 32'h0);
    chk("rd_err", 32'(rd_err), (n > 0) ? 32'(q[0][8]) : 32'h0);
  endtask

  // One clock: drive inputs, advance model on the edge, check 1 time unit later.
  task automatic step(input logic w, input logic [7:0] d, input logic e,
                      input logic r, input logic c);
    bit pop, push;
    wr_stb = w; wr_dat = d; wr_err = e; rd_stb = r; clr = c;
    @(posedge clk);
    if (c) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      pop  = r && (q.size() > 0);
      push = w && ((q.size() < DEPTH) || pop);
      if (w && !push) m_ovr = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back({e, d});
    end
    #1;
    wr_stb = 1'b0; rd_stb = 1'b0; clr = 1'b0;
    chk_model();
  endtask

  initial begin
    logic [7:0] b;
    // Reset and empty read
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_model();
    chk("reset_rd_dat", 32'(rd_dat), 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("empty_pop_count", 32'(count), 32'd0);

    // Fill and threshold
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0);
      chk("fill_head", 32'(rd_dat), 32'h41);
      chk("fill_thresh", 32'(above_thresh), 32'(i + 1 >= THRESH));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);

    // Overrun, then drain
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(rd_dat), 32'(8'h41 + i));
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Error bit and wrap-around: pop every cycle after the first push
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) chk("wrap_head", 32'(rd_dat), 32'(8'hC0 + i - 1));
      if (i > 0) chk("wrap_err", 32'(rd_err), 32'(i == 17));
      step(i < 20, 8'(8'hC0 + i), i == 16, i > 0, 1'b0);
      chk("wrap_cnt_le1", 32'(count <= 1), 32'd1);
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous push/pop at full and empty
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("full_pp_count", 32'(count), 32'd16);
    chk("full_pp_ovr", 32'(overrun), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    chk("empty_pp_count", 32'(count), 32'd1);
    chk("empty_pp_dat", 32'(rd_dat), 32'h5A);

    // clr priority over a concurrent push
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("pre_clr_count", 32'(count), 32'd5);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      b = 8'($urandom);
      step(1'($urandom_range(0, 99) < 60), b, 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));
    end

    // Async reset between edges, mid-burst
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    wr_stb = 1'b1; wr_dat = 8'hAB;
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_ovr = 1'b0;
    chk_model();
    chk("arst_rd_dat", 32'(rd_dat), 32'h00);
    chk("arst_empty", 32'(empty), 32'd1);
    wr_stb = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_model();
    step(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    chk("post_rst_push", 32'(rd_dat), 32'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acia_rx_fifo.md
Name: acia_rx_fifo

Overview:
- Receive-side buffer between the ACIA async receiver strobe output and the CPU-facing data register.
- Absorbs bursts at 115200 baud while the CPU services other work; adds a threshold flag for interrupt generation and a sticky overrun flag.
- Each entry stores the received byte plus its receive-error bit.
- First-word-fall-through read side: head entry is visible without a pop.

Parameters:
DEPTH, 16, number of entries; must be a power of two, >= 2
THRESH, 8, occupancy level at which above_thresh asserts; 1 <= THRESH <= DEPTH
CW, $clog2(DEPTH)+1, count width (derived localparam, not overridable)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous flush; empties FIFO, clears overrun
wr_dat  input  8  received byte from the receiver
wr_err  input  1  receive error (framing/overrun) for wr_dat
wr_stb  input  1  one-cycle push strobe from the receiver
rd_stb  input  1  one-cycle pop strobe from the bus side (data register read)
rd_dat  output  8  head entry byte; 8'h00 when empty
rd_err  output  1  head entry error bit; 0 when empty
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds DEPTH entries
count  output  CW  current occupancy, 0..DEPTH
above_thresh  output  1  count >= THRESH
overrun  output  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (async, rst high): wr_ptr=0, rd_ptr=0, count=0, overrun=0. Outputs: empty=1, full=0, rd_dat=8'h00, rd_err=0, above_thresh=0. The storage array is not reset.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count is a registered up/down counter.
- empty, full and above_thresh are derived combinationally from count.
- Push (wr_stb & ~full):
  - writes {wr_err, wr_dat} at wr_ptr;
  - wr_ptr+1, count+1 on the next clk.
- Pop (rd_stb & ~empty):
  - rd_ptr+1, count-1 on the next clk;
  - the next head appears on rd_dat the cycle after the pop edge.
- Pop while empty is ignored: no pointer or count change, no error.
- Push while full, with no simultaneous pop:
  - byte is dropped;
  - overrun sets on the next clk;
  - storage, pointers and count are unchanged.
- Simultaneous push and pop:
  - not empty and not full: both occur; count unchanged; both pointers advance.
  - full: the pop frees a slot, so the push is accepted; count stays DEPTH; overrun not set.
  - empty: the pop is ignored and the push is accepted; count becomes 1.
- Read latency: a push into an empty FIFO is visible on rd_dat/rd_err and empty=0 one cycle after the wr_stb edge.
- rd_dat/rd_err are a combinational read of storage[rd_ptr], gated to 0 when empty.
- overrun is sticky and clears only on clr or rst.
- clr has priority over push and pop in the same cycle. Next cycle: pointers=0, count=0, overrun=0; the concurrent wr_stb byte is discarded.
- Reset mid-operation: all state returns to the reset values immediately (asynchronously); a byte in flight on wr_stb is lost.
- No combinational path from rd_stb or wr_stb to any output.

Test Plan:
- Reset and empty read:
  - stimulus: assert rst, release; pulse rd_stb;
  - required response: empty=1, count=0, rd_dat=8'h00, overrun=0; count stays 0 after the rd_stb pulse.
- Fill and threshold:
  - stimulus: push 0x41..0x50 (16 bytes, wr_err=0);
  - required response: above_thresh asserts after the 8th push; full=1 and count=16 after the 16th push; rd_dat=0x41 throughout.
- Overrun:
  - stimulus: when full, push 0x99;
  - required response: overrun=1, count=16, no entry holds 0x99.
  - continuation: pop all 16;
  - required response: data order 0x41..0x50; empty=1; overrun remains 1 until a clr pulse, then 0.
- Error bit and wrap-around:
  - stimulus: push 20 bytes while popping every cycle after the first push, with wr_err=1 on the 17th byte;
  - required response: all bytes read in order; rd_err=1 only on the 17th byte; count never exceeds 1.
- Simultaneous at boundaries:
  - full with push+pop in the same cycle: count=16 and overrun=0.
  - empty with push 0x5A and pop in the same cycle: count=1 and rd_dat=0x5A next cycle.
- clr priority and async reset:
  - count=5, then clr with wr_stb in the same cycle: count=0 and empty=1 next cycle.
  - rst asserted mid-burst between clk edges: outputs reach their reset values before the next clk edge.
